// File: rtl/lc3_data_mem_ws_pkg.sv
// Shared types and constants for the LC3 wait-state data memory.
package lc3_data_mem_ws_pkg;

  // Access sequencing states: idle, counting wait states, completion cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Wait counter width; wait states range 0..15.
  localparam int WAIT_CNT_W = 4;

  // Default geometry and timing.
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int DEF_RD_WAIT    = 2;
  localparam int DEF_WR_WAIT    = 1;

endpackage

// File: rtl/lc3_dmem_array.sv
// Single-port synchronous backing store with a registered read port.
// The storage is never reset; rdata only changes on a read access.
module lc3_dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // One access per edge: either write the word or capture it into rdata.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lc3_data_mem_ws.sv
// LC3 data memory with independent read/write wait states, a one-cycle
// completion pulse, out-of-range detection and a busy indication.
module lc3_data_mem_ws
  import lc3_data_mem_ws_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int WR_WAIT    = DEF_WR_WAIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              complete_data,
  output logic              busy,
  output logic              err
);

  localparam logic [WAIT_CNT_W-1:0] RD_W = WAIT_CNT_W'(RD_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WR_W = WAIT_CNT_W'(WR_WAIT);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  logic complete_q;
  logic err_q;
  logic dout_clr_q;

  logic                  accept;
  logic [WAIT_CNT_W-1:0] req_wait;
  logic                  commit;
  logic                  cur_rd;
  logic [ADDR_W-1:0]     cur_addr;
  logic [DATA_W-1:0]     cur_din;
  logic                  cur_oor;

  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Acceptance, commit detection and the effective access. With zero wait
  // states the commit happens on the acceptance edge itself, so the access
  // fields come straight from the inputs instead of the latches.
  always_comb begin
    accept   = 1'b0;
    req_wait = '0;
    commit   = 1'b0;
    cur_rd   = rd_q;
    cur_addr = addr_q;
    cur_din  = din_q;
    cur_oor  = 1'b0;

    accept   = mem_req && ((state_q == IDLE) || (state_q == DONE));
    req_wait = mem_rd ? RD_W : WR_W;
    if (accept) begin
      cur_rd   = mem_rd;
      cur_addr = addr;
      cur_din  = din;
    end
    commit  = (accept && (req_wait == '0)) ||
              ((state_q == WAIT) && (cnt_q == '0));
    cur_oor = (cur_addr >> DEPTH_LOG2) != '0;
  end

  // Next-state and wait counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (req_wait == '0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = req_wait - WAIT_CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array access fires only on the DONE-entry edge; reset blocks it so an
  // aborted write never lands. Out-of-range accesses never touch the array.
  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    ram_en = commit && !reset && !cur_oor;
    ram_we = !cur_rd;
  end

  // State, counter, request latches and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
      dout_clr_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      complete_q <= commit;
      err_q      <= commit && cur_oor;
      if (commit && cur_rd) begin
        dout_clr_q <= cur_oor;
      end
      if (accept) begin
        rd_q   <= mem_rd;
        addr_q <= addr;
        din_q  <= din;
      end
    end
  end

  lc3_dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur_addr[DEPTH_LOG2-1:0]),
    .wdata (cur_din),
    .rdata (ram_rdata)
  );

  assign dout          = dout_clr_q ? '0 : ram_rdata;
  assign complete_data = complete_q;
  assign err           = err_q;
  assign busy          = (state_q == WAIT);

endmodule

// File: tb/tb_lc3_data_mem_ws.sv
// Scoreboard testbench for lc3_data_mem_ws: three instances cover the
// default timing, zero wait states, and the maximum read wait.
module tb_lc3_data_mem_ws;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] req;
  logic [2:0] rd;
  logic [15:0] addr_v [3];
  logic [15:0] din_v [3];
  logic [15:0] dout_v [3];
  logic cd0, cd1, cd2;
  logic busy0, busy1, busy2;
  logic err0, err1, err2;
  logic [2:0] cd, busy, err;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int          dut;
    logic        chk_dout;
    logic [15:0] dout;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];

  logic [15:0] zw_vals [8] = '{16'h1000, 16'h1101, 16'h1202, 16'h1303,
                               16'h1404, 16'h1505, 16'h1606, 16'h1707};

  assign cd   = {cd2, cd1, cd0};
  assign busy = {busy2, busy1, busy0};
  assign err  = {err2, err1, err0};

  always #5 clock = ~clock;

  // Cycle count used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  lc3_data_mem_ws #(.RD_WAIT(2), .WR_WAIT(1)) dut_def (
    .clock(clock), .reset(reset), .mem_req(req[0]), .mem_rd(rd[0]),
    .addr(addr_v[0]), .din(din_v[0]), .dout(dout_v[0]),
    .complete_data(cd0), .busy(busy0), .err(err0));

  lc3_data_mem_ws #(.RD_WAIT(0), .WR_WAIT(0)) dut_zw (
    .clock(clock), .reset(reset), .mem_req(req[1]), .mem_rd(rd[1]),
    .addr(addr_v[1]), .din(din_v[1]), .dout(dout_v[1]),
    .complete_data(cd1), .busy(busy1), .err(err1));

  lc3_data_mem_ws #(.RD_WAIT(15), .WR_WAIT(0)) dut_mx (
    .clock(clock), .reset(reset), .mem_req(req[2]), .mem_rd(rd[2]),
    .addr(addr_v[2]), .din(din_v[2]), .dout(dout_v[2]),
    .complete_data(cd2), .busy(busy2), .err(err2));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic pushExp(input int d, input logic chk, input logic [15:0] ed,
                         input logic ee, input int due);
    exp_t e;
    e.dut      = d;
    e.chk_dout = chk;
    e.dout     = ed;
    e.err      = ee;
    e.due      = due;
    sbq.push_back(e);
  endtask

  // Presents one request at a negedge; it is accepted on the next posedge.
  task automatic applyStimulus(input int d, input logic is_rd, input logic [15:0] a,
                               input logic [15:0] wd, input logic push, input logic chk,
                               input logic [15:0] ed, input logic ee, input int w);
    req[d]    = 1'b1;
    rd[d]     = is_rd;
    addr_v[d] = a;
    din_v[d]  = wd;
    if (push) pushExp(d, chk, ed, ee, cyc + 1 + w);
    @(negedge clock);
    req[d] = 1'b0;
    if (w > 0) checkOutput($sformatf("dut%0d busy after accept", d), {31'd0, busy[d]}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every completion pops the scoreboard and is checked.
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (cd[i] === 1'b1) begin
        checkOutput($sformatf("dut%0d busy in DONE", i), {31'd0, busy[i]}, 32'd0);
        if (sbq.size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected complete", i), {31'd0, cd[i]}, 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput($sformatf("dut%0d completing instance", i), i, e.dut);
          checkOutput($sformatf("dut%0d completion cycle", i), cyc, e.due);
          checkOutput($sformatf("dut%0d err", i), {31'd0, err[i]}, {31'd0, e.err});
          if (e.chk_dout)
            checkOutput($sformatf("dut%0d dout", i), {16'd0, dout_v[i]}, {16'd0, e.dout});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    rd    = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      din_v[i]  = '0;
    end
    idle(3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d reset dout", i), {16'd0, dout_v[i]}, 32'd0);
      checkOutput($sformatf("dut%0d reset complete", i), {31'd0, cd[i]}, 32'd0);
      checkOutput($sformatf("dut%0d reset busy", i), {31'd0, busy[i]}, 32'd0);
      checkOutput($sformatf("dut%0d reset err", i), {31'd0, err[i]}, 32'd0);
    end

    // Default timing: write then read back, read issued in the write's DONE cycle.
    applyStimulus(0, 1'b0, 16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    idle(1);
    applyStimulus(0, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 2);
    idle(3);

    // Preload, chained through DONE cycles.
    applyStimulus(0, 1'b0, 16'h0011, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    idle(1);
    applyStimulus(0, 1'b0, 16'h0000, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    idle(1);
    applyStimulus(0, 1'b0, 16'h00FF, 16'h7777, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    idle(1);
    applyStimulus(0, 1'b0, 16'h0020, 16'h2222, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    idle(1);
    applyStimulus(0, 1'b1, 16'h0011, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1'b0, 2);
    idle(2);

    // Out of range: write discarded (0x0000 alias keeps its data), read gives 0.
    applyStimulus(0, 1'b0, 16'h0100, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    idle(1);
    applyStimulus(0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0F0F, 1'b0, 2);
    idle(2);
    applyStimulus(0, 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 2);
    idle(2);
    applyStimulus(0, 1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h7777, 1'b0, 2);
    idle(3);

    // Request held through WAIT is ignored until the DONE cycle.
    applyStimulus(0, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 2);
    req[0]    = 1'b1;
    rd[0]     = 1'b1;
    addr_v[0] = 16'h0011;
    idle(1);
    checkOutput("dut0 busy while request held", {31'd0, busy[0]}, 32'd1);
    idle(1);
    pushExp(0, 1'b1, 16'hABCD, 1'b0, cyc + 3);
    idle(1);
    req[0] = 1'b0;
    idle(4);

    // Reset in the WAIT cycle of a write aborts it.
    applyStimulus(0, 1'b0, 16'h0020, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("dut0 after abort dout", {16'd0, dout_v[0]}, 32'd0);
    checkOutput("dut0 after abort complete", {31'd0, cd[0]}, 32'd0);
    checkOutput("dut0 after abort busy", {31'd0, busy[0]}, 32'd0);
    checkOutput("dut0 after abort err", {31'd0, err[0]}, 32'd0);
    idle(3);
    applyStimulus(0, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h2222, 1'b0, 2);
    idle(3);

    // Zero wait states: back-to-back writes then reads, one completion per cycle.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1'b0, 16'(i), zw_vals[i], 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1'b1, 16'(i), 16'h0000, 1'b1, 1'b1, zw_vals[i], 1'b0, 0);
    idle(2);

    // Maximum read wait: 16-cycle latency, twice back to back.
    applyStimulus(2, 1'b0, 16'h0003, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    applyStimulus(2, 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h00AA, 1'b0, 15);
    idle(15);
    applyStimulus(2, 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h00AA, 1'b0, 15);
    idle(16);

    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clock);
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
